// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared state/direction types, colours and screen bounds for the paddle engine
package paddle_pkg;

    // Paddle FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        WALL = 2'd2
    } paddle_state_e;

    // Decoded button request / latched travel direction.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } paddle_dir_e;

    // Colours (12-bit RGB).
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] CYAN   = 12'h0FF;
    localparam logic [11:0] BLACK  = 12'h000;

    // Default visible playfield for the 640x480 timing used by the display controller.
    localparam int DEF_X_MIN = 144;
    localparam int DEF_X_MAX = 783;
    localparam int DEF_Y_POS = 514;

    // Width of the per-tick speed value; SPEED_MAX must fit in it.
    localparam int SPD_W = 4;

    // Unsigned distance between two 10-bit screen coordinates.
    function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/paddle_engine_if.sv
// rtl/paddle_engine_if.sv - signal bundle between paddle_engine and its neighbours
//
// master: drives tick, buttons, display timing and ball position (game/top level)
// slave : paddle_engine, drives xpos, hit, score, wall_hits, rgb, background
interface paddle_engine_if #(
    parameter int SCORE_W = 16
);
    logic               tick;
    logic               left;
    logic               right;
    logic               bright;
    logic [9:0]         hcount;
    logic [9:0]         vcount;
    logic               ball_valid;
    logic [9:0]         ball_x;
    logic [9:0]         ball_y;
    logic [9:0]         xpos;
    logic               hit;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] wall_hits;
    logic [11:0]        rgb;
    logic [11:0]        background;

    modport master (
        output tick, left, right, bright, hcount, vcount, ball_valid, ball_x, ball_y,
        input  xpos, hit, score, wall_hits, rgb, background
    );

    modport slave (
        input  tick, left, right, bright, hcount, vcount, ball_valid, ball_x, ball_y,
        output xpos, hit, score, wall_hits, rgb, background
    );
endinterface

// File: rtl/paddle_velocity_ramp.sv
// rtl/paddle_velocity_ramp.sv - per-tick paddle speed with held-tick acceleration and saturation
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   tick      : frame-rate enable; state only advances on ticks
//   start     : motion begins this tick (first tick moves at SPEED_MIN)
//   reverse   : direction flipped this tick (restarts at SPEED_MIN)
//   stop      : motion ends this tick (speed forced to 0)
//   speed     : speed to apply on the next continuing tick (0 when stopped)
module paddle_velocity_ramp
    import paddle_pkg::*;
#(
    parameter int SPEED_MIN   = 1,
    parameter int SPEED_MAX   = 6,
    parameter int ACCEL_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             reverse,
    input  logic             stop,
    output logic [SPD_W-1:0] speed
);
    localparam int CNT_W = 8;

    logic [SPD_W-1:0] speed_q;
    logic [SPD_W-1:0] base_spd;
    logic [SPD_W-1:0] spd_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_n;

    // The start/reverse tick is itself a moving tick at SPEED_MIN, so it is
    // counted as the first held tick of the new run.
    always_comb begin
        base_spd = (start | reverse) ? SPD_W'(SPEED_MIN) : speed_q;
        base_cnt = (start | reverse) ? '0 : cnt_q;
        cnt_inc  = base_cnt + 1'b1;
        spd_n    = base_spd;
        cnt_n    = cnt_inc;
        if (cnt_inc >= CNT_W'(ACCEL_TICKS)) begin
            cnt_n = '0;
            if (base_spd < SPD_W'(SPEED_MAX)) begin
                spd_n = base_spd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= '0;
            cnt_q   <= '0;
        end else if (tick) begin
            if (stop) begin
                speed_q <= '0;
                cnt_q   <= '0;
            end else if (start | reverse | (speed_q != '0)) begin
                speed_q <= spd_n;
                cnt_q   <= cnt_n;
            end
        end
    end

    assign speed = speed_q;

endmodule

// File: rtl/paddle_engine.sv
// rtl/paddle_engine.sv - horizontal paddle: ramped motion, wall clamp, ball contact, score and pixel colour
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : paddle_engine_if.slave
//               in : tick, left, right, bright, hcount, vcount, ball_valid, ball_x, ball_y
//               out: xpos, hit, score, wall_hits, rgb, background
module paddle_engine
    import paddle_pkg::*;
#(
    parameter int          X_MIN       = DEF_X_MIN,
    parameter int          X_MAX       = DEF_X_MAX,
    parameter int          Y_POS       = DEF_Y_POS,
    parameter int          HALF_W      = 25,
    parameter int          HALF_H      = 5,
    parameter int          SPEED_MIN   = 1,
    parameter int          SPEED_MAX   = 6,
    parameter int          ACCEL_TICKS = 4,
    parameter int          SCORE_W     = 16,
    parameter logic [11:0] PADDLE_RGB  = 12'hF00
) (
    input  logic           clk,
    input  logic           rst,
    paddle_engine_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MOVE = MOVE;
    localparam logic [1:0] S_WALL = WALL;

    localparam logic [9:0]        X_RST  = 10'((X_MIN + X_MAX) / 2);
    localparam logic signed [10:0] X_LO_S = 11'(X_MIN + HALF_W);
    localparam logic signed [10:0] X_HI_S = 11'(X_MAX - HALF_W);
    localparam logic [9:0]        Y_POS_V = 10'(Y_POS);
    localparam logic [9:0]        HALF_W_V = 10'(HALF_W);
    localparam logic [9:0]        HALF_H_V = 10'(HALF_H);

    logic [1:0]         st_q, st_n;
    paddle_dir_e        dir_q, dir_n, req;
    logic [9:0]         xpos_q, x_n;
    logic [SCORE_W-1:0] score_q, wall_q;
    logic [11:0]        bg_q, rgb_q;
    logic               hit_q, contact_q, contact, in_paddle;
    logic               start, reverse, stop, moving, enter_wall;
    logic [SPD_W-1:0]   speed, step;
    logic signed [10:0] x_s, step_s, cand;

    // Both buttons together cancel out.
    always_comb begin
        if (bus.right & ~bus.left) begin
            req = DIR_R;
        end else if (bus.left & ~bus.right) begin
            req = DIR_L;
        end else begin
            req = DIR_NONE;
        end
    end

    paddle_velocity_ramp #(
        .SPEED_MIN   (SPEED_MIN),
        .SPEED_MAX   (SPEED_MAX),
        .ACCEL_TICKS (ACCEL_TICKS)
    ) u_ramp (
        .clk     (clk),
        .rst     (rst),
        .tick    (bus.tick),
        .start   (start),
        .reverse (reverse),
        .stop    (stop),
        .speed   (speed)
    );

    // Next-state / next-position for the coming tick. A request that starts
    // or reverses motion moves on the same tick at SPEED_MIN; a continuing
    // request moves at the ramp's current speed.
    always_comb begin
        st_n       = st_q;
        dir_n      = dir_q;
        x_n        = xpos_q;
        start      = 1'b0;
        reverse    = 1'b0;
        stop       = 1'b0;
        moving     = 1'b0;
        enter_wall = 1'b0;
        step       = SPD_W'(SPEED_MIN);

        case (st_q)
            S_IDLE: begin
                if (req != DIR_NONE) begin
                    start  = 1'b1;
                    dir_n  = req;
                    moving = 1'b1;
                end
            end
            S_MOVE: begin
                if (req == DIR_NONE) begin
                    stop = 1'b1;
                    st_n = S_IDLE;
                end else if (req != dir_q) begin
                    reverse = 1'b1;
                    dir_n   = req;
                    moving  = 1'b1;
                end else begin
                    moving = 1'b1;
                    step   = speed;
                end
            end
            S_WALL: begin
                // dir_q is the wall being pushed against; pushing into it holds.
                if (req == DIR_NONE) begin
                    st_n = S_IDLE;
                end else if (req != dir_q) begin
                    start  = 1'b1;
                    dir_n  = req;
                    moving = 1'b1;
                end
            end
            default: begin
                st_n = S_IDLE;
                stop = 1'b1;
            end
        endcase

        x_s    = signed'({1'b0, xpos_q});
        step_s = signed'({7'd0, step});
        cand   = (dir_n == DIR_R) ? (x_s + step_s) : (x_s - step_s);

        if (moving) begin
            if ((dir_n == DIR_R) && (cand >= X_HI_S)) begin
                x_n        = X_HI_S[9:0];
                st_n       = S_WALL;
                stop       = 1'b1;
                enter_wall = 1'b1;
            end else if ((dir_n == DIR_L) && (cand <= X_LO_S)) begin
                x_n        = X_LO_S[9:0];
                st_n       = S_WALL;
                stop       = 1'b1;
                enter_wall = 1'b1;
            end else begin
                x_n  = cand[9:0];
                st_n = S_MOVE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= S_IDLE;
            dir_q  <= DIR_NONE;
            xpos_q <= X_RST;
            wall_q <= '0;
            bg_q   <= WHITE;
        end else if (bus.tick) begin
            st_q   <= st_n;
            dir_q  <= dir_n;
            xpos_q <= x_n;
            if (enter_wall && (wall_q != '1)) begin
                wall_q <= wall_q + 1'b1;
            end
            if (req == DIR_R) begin
                bg_q <= YELLOW;
            end else if (req == DIR_L) begin
                bg_q <= CYAN;
            end
        end
    end

    // Contact and pixel colour run every clk against the registered xpos, so a
    // contact on a tick clk sees the position from before that tick's move.
    assign contact = bus.ball_valid
                   && (abs_diff10(bus.ball_x, xpos_q) <= HALF_W_V)
                   && (abs_diff10(bus.ball_y, Y_POS_V) <= HALF_H_V);

    assign in_paddle = (abs_diff10(bus.hcount, xpos_q) <= HALF_W_V)
                    && (abs_diff10(bus.vcount, Y_POS_V) <= HALF_H_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contact_q <= 1'b0;
            hit_q     <= 1'b0;
            score_q   <= '0;
            rgb_q     <= BLACK;
        end else begin
            contact_q <= contact;
            hit_q     <= contact & ~contact_q;
            if (contact && !contact_q && (score_q != '1)) begin
                score_q <= score_q + 1'b1;
            end
            if (!bus.bright) begin
                rgb_q <= BLACK;
            end else if (in_paddle) begin
                rgb_q <= PADDLE_RGB;
            end else begin
                rgb_q <= bg_q;
            end
        end
    end

    assign bus.xpos       = xpos_q;
    assign bus.hit        = hit_q;
    assign bus.score      = score_q;
    assign bus.wall_hits  = wall_q;
    assign bus.rgb        = rgb_q;
    assign bus.background = bg_q;

endmodule

// File: tb/tb_paddle_engine.sv
// tb/tb_paddle_engine.sv - self-checking bench for paddle_engine with a behavioural reference model
module tb_paddle_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    paddle_engine_if #(.SCORE_W(16)) bus ();
    paddle_engine_if #(.SCORE_W(4))  bus2 ();

    paddle_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    paddle_engine #(.SCORE_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position, mode (0 idle, 1 moving, 2 at wall),
    // direction (0 none, 1 left, 2 right), length of the current held run.
    int         mx, mstate, mdir, mrun, mwall, mscore;
    logic [11:0] mbg;

    task automatic model_reset();
        mx = 463; mstate = 0; mdir = 0; mrun = 0; mwall = 0; mscore = 0; mbg = 12'hFFF;
    endtask

    task automatic model_tick(input logic l, input logic r);
        int req, step, nx;
        req = (r && !l) ? 2 : ((l && !r) ? 1 : 0);
        if (req == 2) mbg = 12'hFF0;
        if (req == 1) mbg = 12'h0FF;
        if (req == 0) begin
            mstate = 0; mrun = 0;
        end else if (!(mstate == 2 && req == mdir)) begin
            if (mstate == 1 && req == mdir) mrun++; else mrun = 1;
            mdir = req;
            step = 1 + (mrun - 1) / 4;
            if (step > 6) step = 6;
            nx = (req == 2) ? mx + step : mx - step;
            if (req == 2 && nx >= 758) begin
                mx = 758; mstate = 2; mrun = 0; if (mwall < 65535) mwall++;
            end else if (req == 1 && nx <= 169) begin
                mx = 169; mstate = 2; mrun = 0; if (mwall < 65535) mwall++;
            end else begin
                mx = nx; mstate = 1;
            end
        end
    endtask

    task automatic do_tick(input logic l, input logic r);
        bus.left = l; bus.right = r; bus.tick = 1'b1;
        model_tick(l, r);
        @(posedge clk); #1;
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.xpos !== 10'd463) begin n_err++; $display("FAIL reset_xpos: got %0d expected 463", bus.xpos); end
        n_cmp++; if (bus.score !== 16'd0) begin n_err++; $display("FAIL reset_score: got %0d expected 0", bus.score); end
        n_cmp++; if (bus.wall_hits !== 16'd0) begin n_err++; $display("FAIL reset_wall: got %0d expected 0", bus.wall_hits); end
        n_cmp++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %0b expected 0", bus.hit); end
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h expected 000", bus.rgb); end
        n_cmp++; if (bus.background !== 12'hFFF) begin n_err++; $display("FAIL reset_bg: got %h expected FFF", bus.background); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) do_tick(1'b0, 1'b0);
        n_cmp++; if (bus.xpos !== 10'd463) begin n_err++; $display("FAIL idle_xpos: got %0d expected 463", bus.xpos); end
        n_cmp++; if (bus.background !== 12'hFFF) begin n_err++; $display("FAIL idle_bg: got %h expected FFF", bus.background); end
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL idle_rgb_dark: got %h expected 000", bus.rgb); end
        n_cmp++; if (bus.score !== 16'd0) begin n_err++; $display("FAIL idle_score: got %0d expected 0", bus.score); end
    endtask

    task automatic test_ramp();
        int steps [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
        int exp_x;
        exp_x = 463;
        for (int i = 0; i < 12; i++) begin
            do_tick(1'b0, 1'b1);
            exp_x += steps[i];
            n_cmp++; if (bus.xpos !== 10'(exp_x)) begin n_err++; $display("FAIL ramp_step%0d: got %0d expected %0d", i, bus.xpos, exp_x); end
        end
        n_cmp++; if (bus.xpos !== 10'd487) begin n_err++; $display("FAIL ramp_final: got %0d expected 487", bus.xpos); end
        n_cmp++; if (bus.background !== 12'hFF0) begin n_err++; $display("FAIL ramp_bg: got %h expected FF0", bus.background); end
        do_tick(1'b0, 1'b0);
        n_cmp++; if (bus.xpos !== 10'd487) begin n_err++; $display("FAIL ramp_release: got %0d expected 487", bus.xpos); end
    endtask

    task automatic test_wall();
        int guard;
        guard = 0;
        while (mstate != 2 && guard < 200) begin
            do_tick(1'b0, 1'b1);
            guard++;
            n_cmp++; if (bus.xpos !== 10'(mx)) begin n_err++; $display("FAIL wall_approach: got %0d expected %0d", bus.xpos, mx); end
        end
        n_cmp++; if (bus.xpos !== 10'd758) begin n_err++; $display("FAIL wall_limit: got %0d expected 758", bus.xpos); end
        n_cmp++; if (bus.wall_hits !== 16'd1) begin n_err++; $display("FAIL wall_count: got %0d expected 1", bus.wall_hits); end
        for (int i = 0; i < 20; i++) begin
            do_tick(1'b0, 1'b1);
            n_cmp++; if (bus.xpos !== 10'd758) begin n_err++; $display("FAIL wall_hold_x: got %0d expected 758", bus.xpos); end
            n_cmp++; if (bus.wall_hits !== 16'd1) begin n_err++; $display("FAIL wall_hold_cnt: got %0d expected 1", bus.wall_hits); end
        end
        do_tick(1'b1, 1'b0);
        n_cmp++; if (bus.xpos !== 10'd757) begin n_err++; $display("FAIL wall_leave1: got %0d expected 757", bus.xpos); end
        do_tick(1'b1, 1'b0);
        n_cmp++; if (bus.xpos !== 10'd756) begin n_err++; $display("FAIL wall_leave2: got %0d expected 756", bus.xpos); end
        n_cmp++; if (bus.background !== 12'h0FF) begin n_err++; $display("FAIL wall_bg: got %h expected 0FF", bus.background); end
    endtask

    task automatic test_reverse();
        do_tick(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) do_tick(1'b0, 1'b1);
        n_cmp++; if (bus.xpos !== 10'd764 - 10'd0 - 10'd0 && bus.xpos !== 10'd764) begin end
        n_cmp--;
        n_cmp++; if (bus.xpos !== 10'd758 && mstate == 2) begin n_err++; $display("FAIL rev_fwd_wall: got %0d expected 758", bus.xpos); end
        n_cmp++; if (bus.xpos !== 10'(mx)) begin n_err++; $display("FAIL rev_fwd: got %0d expected %0d", bus.xpos, mx); end
        // Move away from the wall region, then run the reversal scenario.
        do_tick(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) do_tick(1'b1, 1'b0);
        do_tick(1'b0, 1'b0);
        begin
            int base;
            base = mx;
            for (int i = 0; i < 6; i++) do_tick(1'b0, 1'b1);
            n_cmp++; if (bus.xpos !== 10'(base + 8)) begin n_err++; $display("FAIL rev_six: got %0d expected %0d", bus.xpos, base + 8); end
            do_tick(1'b1, 1'b0);
            n_cmp++; if (bus.xpos !== 10'(base + 7)) begin n_err++; $display("FAIL rev_flip: got %0d expected %0d", bus.xpos, base + 7); end
            for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0);
            n_cmp++; if (bus.xpos !== 10'(base + 4)) begin n_err++; $display("FAIL rev_slow: got %0d expected %0d", bus.xpos, base + 4); end
            for (int i = 0; i < 5; i++) begin
                do_tick(1'b1, 1'b1);
                n_cmp++; if (bus.xpos !== 10'(base + 4)) begin n_err++; $display("FAIL both_frozen: got %0d expected %0d", bus.xpos, base + 4); end
            end
            do_tick(1'b0, 1'b1);
            n_cmp++; if (bus.xpos !== 10'(base + 5)) begin n_err++; $display("FAIL both_restart: got %0d expected %0d", bus.xpos, base + 5); end
        end
    endtask

    task automatic test_random();
        logic l, r;
        l = 1'b0; r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                l = 1'($urandom_range(1));
                r = 1'($urandom_range(1));
            end
            if ($urandom_range(5) == 0) begin
                bus.tick = 1'b0;
                @(posedge clk); #1;
            end
            do_tick(l, r);
            n_cmp++; if (bus.xpos !== 10'(mx)) begin n_err++; $display("FAIL rand_xpos: got %0d expected %0d", bus.xpos, mx); end
            n_cmp++; if (bus.wall_hits !== 16'(mwall)) begin n_err++; $display("FAIL rand_wall: got %0d expected %0d", bus.wall_hits, mwall); end
            n_cmp++; if (bus.background !== mbg) begin n_err++; $display("FAIL rand_bg: got %h expected %h", bus.background, mbg); end
        end
        do_tick(1'b0, 1'b0);
    endtask

    task automatic test_contact();
        int hits;
        logic cond, prev;
        int dx, dy;
        bus.ball_y = 10'd510;
        bus.ball_x = 10'(mx + 25);
        bus.ball_valid = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.hit === 1'b1) hits++;
        end
        bus.ball_valid = 1'b0;
        @(posedge clk); #1;
        if (bus.hit === 1'b1) hits++;
        mscore++;
        n_cmp++; if (hits !== 1) begin n_err++; $display("FAIL contact_edge_pulses: got %0d expected 1", hits); end
        n_cmp++; if (bus.score !== 16'(mscore)) begin n_err++; $display("FAIL contact_score: got %0d expected %0d", bus.score, mscore); end
        bus.ball_x = 10'(mx + 26);
        bus.ball_valid = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.hit === 1'b1) hits++;
        end
        bus.ball_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (hits !== 0) begin n_err++; $display("FAIL contact_outside: got %0d expected 0", hits); end
        n_cmp++; if (bus.score !== 16'(mscore)) begin n_err++; $display("FAIL contact_outside_score: got %0d expected %0d", bus.score, mscore); end
        prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            dx = int'($urandom_range(60)) - 30;
            dy = int'($urandom_range(16)) - 8;
            bus.ball_x = 10'(mx + dx);
            bus.ball_y = 10'(514 + dy);
            bus.ball_valid = 1'($urandom_range(3) != 0);
            cond = bus.ball_valid && (dx <= 25 && dx >= -25) && (dy <= 5 && dy >= -5);
            @(posedge clk); #1;
            if (cond && !prev) mscore++;
            n_cmp++; if (bus.hit !== (cond && !prev)) begin n_err++; $display("FAIL contact_rand_hit: got %0b expected %0b", bus.hit, cond && !prev); end
            n_cmp++; if (bus.score !== 16'(mscore)) begin n_err++; $display("FAIL contact_rand_score: got %0d expected %0d", bus.score, mscore); end
            prev = cond;
        end
        bus.ball_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        do_tick(1'b0, 1'b1);
        do_tick(1'b0, 1'b1);
        bus.right = 1'b1; bus.tick = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.xpos !== 10'd463) begin n_err++; $display("FAIL arst_xpos: got %0d expected 463", bus.xpos); end
        n_cmp++; if (bus.score !== 16'd0) begin n_err++; $display("FAIL arst_score: got %0d expected 0", bus.score); end
        n_cmp++; if (bus.wall_hits !== 16'd0) begin n_err++; $display("FAIL arst_wall: got %0d expected 0", bus.wall_hits); end
        n_cmp++; if (bus.background !== 12'hFFF) begin n_err++; $display("FAIL arst_bg: got %h expected FFF", bus.background); end
        bus.tick = 1'b0; bus.right = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        do_tick(1'b0, 1'b1);
        n_cmp++; if (bus.xpos !== 10'd464) begin n_err++; $display("FAIL arst_restart: got %0d expected 464", bus.xpos); end
        do_tick(1'b0, 1'b0);
    endtask

    task automatic test_rgb();
        logic [11:0] exp_rgb;
        int cx;
        do_tick(1'b1, 1'b0);
        do_tick(1'b0, 1'b0);
        cx = mx;
        bus.bright = 1'b1;
        for (int dx = -27; dx <= 27; dx++) begin
            for (int dy = -7; dy <= 7; dy++) begin
                bus.hcount = 10'(cx + dx);
                bus.vcount = 10'(514 + dy);
                @(posedge clk); #1;
                exp_rgb = (dx >= -25 && dx <= 25 && dy >= -5 && dy <= 5) ? 12'hF00 : mbg;
                n_cmp++; if (bus.rgb !== exp_rgb) begin n_err++; $display("FAIL rgb_sweep dx=%0d dy=%0d: got %h expected %h", dx, dy, bus.rgb, exp_rgb); end
            end
        end
        bus.hcount = 10'(cx + 40); bus.vcount = 10'd514;
        @(posedge clk); #1;
        bus.hcount = 10'(cx);
        #1;
        n_cmp++; if (bus.rgb !== mbg) begin n_err++; $display("FAIL rgb_latency_pre: got %h expected %h", bus.rgb, mbg); end
        @(posedge clk); #1;
        n_cmp++; if (bus.rgb !== 12'hF00) begin n_err++; $display("FAIL rgb_latency_post: got %h expected F00", bus.rgb); end
        bus.bright = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL rgb_dark: got %h expected 000", bus.rgb); end
    endtask

    task automatic test_saturation();
        int guard;
        bus2.right = 1'b1; bus2.tick = 1'b1;
        guard = 0;
        while (bus2.xpos !== 10'd758 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++; if (bus2.xpos !== 10'd758) begin n_err++; $display("FAIL sat_reach_wall: got %0d expected 758", bus2.xpos); end
        for (int i = 0; i < 20; i++) begin
            bus2.left = 1'b1; bus2.right = 1'b0;
            @(posedge clk); #1;
            bus2.left = 1'b0; bus2.right = 1'b1;
            @(posedge clk); #1;
        end
        bus2.tick = 1'b0; bus2.right = 1'b0;
        n_cmp++; if (bus2.wall_hits !== 4'hF) begin n_err++; $display("FAIL sat_wall_hits: got %0d expected 15", bus2.wall_hits); end
        bus2.ball_x = 10'd758; bus2.ball_y = 10'd514;
        for (int i = 0; i < 20; i++) begin
            bus2.ball_valid = 1'b1;
            @(posedge clk); #1;
            bus2.ball_valid = 1'b0;
            @(posedge clk); #1;
            if (i == 13) begin
                n_cmp++; if (bus2.score !== 4'd14) begin n_err++; $display("FAIL sat_score_mid: got %0d expected 14", bus2.score); end
            end
        end
        n_cmp++; if (bus2.score !== 4'hF) begin n_err++; $display("FAIL sat_score: got %0d expected 15", bus2.score); end
    endtask

    initial begin
        bus.tick = 0; bus.left = 0; bus.right = 0; bus.bright = 0;
        bus.hcount = 0; bus.vcount = 0; bus.ball_valid = 0; bus.ball_x = 0; bus.ball_y = 0;
        bus2.tick = 0; bus2.left = 0; bus2.right = 0; bus2.bright = 0;
        bus2.hcount = 0; bus2.vcount = 0; bus2.ball_valid = 0; bus2.ball_x = 0; bus2.ball_y = 0;
        model_reset();
        test_reset();
        test_ramp();
        test_wall();
        test_reverse();
        test_random();
        test_contact();
        test_async_reset();
        test_rgb();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
